botrom_loader: RTL

//  Writer side of the bottom ROM. Receives a framed byte stream and writes one byte per ROM word,
//  at sequential addresses from 0. The ROM index is {NZVC[3:0], PC[7:0]}, so wr_addr maps directly.

---
 rtl/botrom_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/botrom_loader.sv
// botrom_loader: frames a host byte stream into sequential bottom-ROM writes and verifies an additive checksum.
// Optional idle-timeout while loading is enabled by defining BOTROM_LOADER_TIMEOUT_EN.
module botrom_loader #(
    parameter int unsigned          ADDR_W  = 12,
    parameter int unsigned          DATA_W  = 8,
    parameter logic [DATA_W-1:0]    SYNC    = 8'h55,
    parameter int unsigned          TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    input  logic              abort,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_cause
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] total;
    logic              active;
    logic              acc;
    assign active   = state == LOAD || state == CHECK;
    assign in_ready = state == IDLE || active;
    assign busy     = active;
    assign done     = state == DONE;
    assign error    = state == ERR;
    assign total    = sum + in_data;
    // abort wins over a byte offered in the same cycle
    assign acc      = in_valid && in_ready && !(active && abort);
`ifdef BOTROM_LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          expired;
    assign expired = active && !acc && tcnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tcnt <= '0;
        else
            tcnt <= (!active || acc) ? '0 : tcnt + 1'b1;
    end
`else
    logic expired;
    assign expired = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sum       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err_cause <= 2'b00;
        end else begin
            wr_en <= 1'b0;
            if (active && abort) begin
                state     <= ERR;
                err_cause <= 2'b10;
            end else if (expired) begin
                state     <= ERR;
                err_cause <= 2'b11;
            end else if ((state == DONE || state == ERR) && clear) begin
                state     <= IDLE;
                cnt       <= '0;
                sum       <= '0;
                err_cause <= 2'b00;
            end else if (acc) begin
                case (state)
                    IDLE: if (in_data == SYNC) begin
                        state <= LOAD;
                        sum   <= '0;
                    end
                    LOAD: begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt;
                        wr_data <= in_data;
                        cnt     <= cnt + 1'b1;
                        sum     <= total;
                        if (&cnt) state <= CHECK;
                    end
                    CHECK: begin
                        state     <= (total == '0) ? DONE : ERR;
                        err_cause <= (total == '0) ? 2'b00 : 2'b01;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
